// File: rtl/rv32_io_responder.sv
// Memory-mapped IO responder for the MEM stage: LED register, debounced push-key with sticky press, prescaled timer with compare match.
// Latency: writes land on the next clk edge; io_rdata is registered and valid one cycle after io_re, like the data RAM.
// Backpressure: none; every io_re/io_we strobe completes in its own cycle, and accesses outside the window are ignored.
module rv32_io_responder #(
    parameter logic [31:0] IO_BASE         = 32'h0001_0000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned PRESCALE        = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] io_addr,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [3:0]  io_be,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        PUSH_KEY,
    output logic [3:0]  LEDS,
    output logic        event_pend
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]     PS_LAST = 16'(PRESCALE - 1);

    localparam logic [2:0] OFF_LED     = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_COUNT   = 3'd2;
    localparam logic [2:0] OFF_COMPARE = 3'd3;
    localparam logic [2:0] OFF_CTRL    = 3'd4;

    logic            hit;
    logic [2:0]      off;
    logic            rd_hit;
    logic            wr_hit;
    logic            led_wr;
    logic            cmp_wr;
    logic            ctrl_wr;
    logic            stat_rd;
    logic            timer_clr;

    logic            key_meta;
    logic            key_sync;
    logic            key_stable;
    logic [DB_W-1:0] db_cnt;
    logic            press_evt;

    logic [3:0]      led_q;
    logic [31:0]     compare_q;
    logic            timer_en;
    logic [15:0]     presc;
    logic [31:0]     count_q;
    logic            tick;
    logic            match_evt;

    logic            sticky_press;
    logic            sticky_match;
    logic [31:0]     rd_val;

    // Byte lane within a word is irrelevant to this word-only register file.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^io_addr[1:0];

    // Address decode: 32-byte window, word offset from bits [4:2].
    assign hit       = (io_addr[31:5] == IO_BASE[31:5]);
    assign off       = io_addr[4:2];
    assign rd_hit    = io_re & hit;
    assign wr_hit    = io_we & hit;
    assign led_wr    = wr_hit & (off == OFF_LED)  & io_be[0];
    assign cmp_wr    = wr_hit & (off == OFF_COMPARE);
    assign ctrl_wr   = wr_hit & (off == OFF_CTRL) & io_be[0];
    assign stat_rd   = rd_hit & (off == OFF_STATUS);
    assign timer_clr = ctrl_wr & io_wdata[1];

    // Two-flop synchroniser for the asynchronous key input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= PUSH_KEY;
            key_sync <= key_meta;
        end
    end

    // Debounce: accept the synchronised level once it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_stable <= 1'b0;
            db_cnt     <= '0;
        end else if (key_sync == key_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            key_stable <= key_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // A press is the edge on which the debounced level goes 0 -> 1.
    assign press_evt = key_sync & ~key_stable & (db_cnt == DB_LAST);

    // LED register, low nibble of byte lane 0 only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= 4'h0;
        end else if (led_wr) begin
            led_q <= io_wdata[3:0];
        end
    end

    // Compare register with per-byte write enables.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            compare_q <= 32'h0;
        end else if (cmp_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (io_be[b]) begin
                    compare_q[8*b +: 8] <= io_wdata[8*b +: 8];
                end
            end
        end
    end

    assign tick = timer_en & (presc == PS_LAST);

    // Timer: enable bit, prescaler and count; a clear request overrides a coincident tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_en <= 1'b0;
            presc    <= 16'h0;
            count_q  <= 32'h0;
        end else begin
            if (ctrl_wr) begin
                timer_en <= io_wdata[0];
            end
            if (timer_clr) begin
                presc   <= 16'h0;
                count_q <= 32'h0;
            end else if (tick) begin
                presc   <= 16'h0;
                count_q <= count_q + 32'd1;
            end else if (timer_en) begin
                presc <= presc + 16'd1;
            end
        end
    end

    // Match fires only when the count steps onto COMPARE, never on a static equality.
    assign match_evt = tick & ~timer_clr & ((count_q + 32'd1) == compare_q);

    // Sticky event bits: cleared by a STATUS read unless a new event lands on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_press <= 1'b0;
            sticky_match <= 1'b0;
        end else if (stat_rd) begin
            sticky_press <= press_evt;
            sticky_match <= match_evt;
        end else begin
            sticky_press <= sticky_press | press_evt;
            sticky_match <= sticky_match | match_evt;
        end
    end

    // Read mux over the pre-edge register values; reserved offsets read zero.
    always_comb begin
        rd_val = 32'h0;
        case (off)
            OFF_LED:     rd_val = {28'h0, led_q};
            OFF_STATUS:  rd_val = {29'h0, sticky_match, sticky_press, key_stable};
            OFF_COUNT:   rd_val = count_q;
            OFF_COMPARE: rd_val = compare_q;
            OFF_CTRL:    rd_val = {31'h0, timer_en};
            default:     rd_val = 32'h0;
        endcase
    end

    // Registered read data, holding its value between hits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_rdata <= 32'h0;
        end else if (rd_hit) begin
            io_rdata <= rd_val;
        end
    end

    assign LEDS       = led_q;
    assign event_pend = sticky_press | sticky_match;

endmodule

// File: tb/tb_rv32_io_responder.sv
module tb_rv32_io_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int DB = 16;
    localparam int PS = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_addr = '0;
    logic        io_re = 1'b0;
    logic        io_we = 1'b0;
    logic [3:0]  io_be = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        PUSH_KEY = 1'b0;
    logic [3:0]  LEDS;
    logic        event_pend;

    int nvec = 0;
    int nerr = 0;

    rv32_io_responder #(
        .IO_BASE(BASE),
        .DEBOUNCE_CYCLES(DB),
        .PRESCALE(PS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_addr(io_addr),
        .io_re(io_re),
        .io_we(io_we),
        .io_be(io_be),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .PUSH_KEY(PUSH_KEY),
        .LEDS(LEDS),
        .event_pend(event_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic re, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
        io_re = re; io_we = we; io_addr = a; io_be = be; io_wdata = wd;
        @(posedge clk); #1;
        io_re = 1'b0; io_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 4'h0, 32'h0);
    endtask

    task automatic apply_reset();
        io_re = 1'b0; io_we = 1'b0; PUSH_KEY = 1'b0;
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [3:0]      m_led;
    logic            m_stable, m_sp, m_sm, m_en;
    longint unsigned m_encyc;      // enabled cycles since last clear; COUNT = m_encyc / PS
    logic [31:0]     m_cmp, m_rdata;
    logic            raw_q[$];     // raw key samples, one per edge
    logic            sync_hist[$]; // synchronised key seen at each edge, newest last

    function automatic logic [31:0] m_count(input longint unsigned c);
        return 32'(c / PS);
    endfunction

    task automatic model_reset();
        m_led = 4'h0; m_stable = 1'b0; m_sp = 1'b0; m_sm = 1'b0; m_en = 1'b0;
        m_encyc = 0; m_cmp = 32'h0; m_rdata = 32'h0;
        raw_q.delete(); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
        sync_hist.delete();
    endtask

    task automatic model_step(input logic re, input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd, input logic key);
        logic hit, sync_now, flip, press, tick, clr, match;
        int off;
        logic [31:0] rv;
        hit = ((addr >> 5) == (BASE >> 5));
        off = int'(addr[4:2]);
        sync_now = raw_q[raw_q.size() - 2];
        raw_q.push_back(key);
        if (raw_q.size() > 4) void'(raw_q.pop_front());
        sync_hist.push_back(sync_now);
        if (sync_hist.size() > DB) void'(sync_hist.pop_front());
        flip = (sync_hist.size() == DB);
        foreach (sync_hist[i]) if (sync_hist[i] == m_stable) flip = 1'b0;
        press = flip && sync_now;
        case (off)
            0: rv = {28'h0, m_led};
            1: rv = {29'h0, m_sm, m_sp, m_stable};
            2: rv = m_count(m_encyc);
            3: rv = m_cmp;
            4: rv = {31'h0, m_en};
            default: rv = 32'h0;
        endcase
        tick  = m_en && (((m_encyc + 1) % PS) == 0);
        clr   = we && hit && off == 4 && be[0] && wd[1];
        match = tick && !clr && (m_count(m_encyc + 1) == m_cmp);
        if (re && hit) m_rdata = rv;
        if (re && hit && off == 1) begin
            m_sp = press; m_sm = match;
        end else begin
            m_sp = m_sp | press; m_sm = m_sm | match;
        end
        if (clr) m_encyc = 0;
        else if (m_en) m_encyc = m_encyc + 1;
        if (flip) m_stable = ~m_stable;
        if (we && hit) begin
            if (off == 0 && be[0]) m_led = wd[3:0];
            if (off == 3) for (int b = 0; b < 4; b++) if (be[b]) m_cmp[8*b +: 8] = wd[8*b +: 8];
            if (off == 4 && be[0]) m_en = wd[0];
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        re;
        logic        we;
        logic [7:0]  off;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_led;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1'b0, 1'b1, 8'h00, 4'b0001, 32'h0000_000A, 1'b0, 32'h0,          4'hA});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 4'b0000, 32'h0,         1'b1, 32'h0000_000A, 4'hA});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 4'b0000, 32'h0000_0005, 1'b0, 32'h0,          4'hA});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 4'b0000, 32'h0,         1'b1, 32'h0000_000A, 4'hA});
        tbl.push_back('{1'b1, 1'b0, 8'h18, 4'b0000, 32'h0,         1'b1, 32'h0,          4'hA});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 4'b0000, 32'h0,         1'b1, 32'h0000_000A, 4'hA});
        tbl.push_back('{1'b1, 1'b0, 8'h40, 4'b0000, 32'h0,         1'b1, 32'h0000_000A, 4'hA});
        tbl.push_back('{1'b0, 1'b1, 8'h0C, 4'b0101, 32'h1122_3344, 1'b0, 32'h0,          4'hA});
        tbl.push_back('{1'b1, 1'b0, 8'h0C, 4'b0000, 32'h0,         1'b1, 32'h0022_0044, 4'hA});
        tbl.push_back('{1'b0, 1'b1, 8'h0C, 4'b1010, 32'hAABB_CCDD, 1'b0, 32'h0,          4'hA});
        tbl.push_back('{1'b1, 1'b0, 8'h0C, 4'b0000, 32'h0,         1'b1, 32'hAA22_CC44, 4'hA});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 4'b1111, 32'hFFFF_FFF3, 1'b0, 32'h0,          4'h3});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 4'b0000, 32'h0,         1'b1, 32'h0000_0003, 4'h3});
        tbl.push_back('{1'b0, 1'b1, 8'h14, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0,          4'h3});
        tbl.push_back('{1'b1, 1'b0, 8'h14, 4'b0000, 32'h0,         1'b1, 32'h0,          4'h3});
        tbl.push_back('{1'b1, 1'b0, 8'h10, 4'b0000, 32'h0,         1'b1, 32'h0,          4'h3});
        tbl.push_back('{1'b1, 1'b0, 8'h08, 4'b0000, 32'h0,         1'b1, 32'h0,          4'h3});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 4'b0001, 32'h0000_0009, 1'b1, 32'h0000_0003, 4'h9});
        tbl.push_back('{1'b1, 1'b0, 8'h02, 4'b0000, 32'h0,         1'b1, 32'h0000_0009, 4'h9});
        tbl.push_back('{1'b1, 1'b0, 8'h04, 4'b0000, 32'h0,         1'b1, 32'h0,          4'h9});
        tbl.push_back('{1'b1, 1'b0, 8'h1C, 4'b0000, 32'h0,         1'b1, 32'h0,          4'h9});

        // reset state
        #2 reset = 1'b0;
        #1;
        check("reset rdata", io_rdata, 32'h0);
        check("reset leds", {28'h0, LEDS}, 32'h0);
        check("reset event_pend", {31'h0, event_pend}, 32'h0);
        @(negedge clk); reset = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].re, tbl[i].we, BASE + 32'(tbl[i].off), tbl[i].be, tbl[i].wd);
            if (tbl[i].chk_rd) check($sformatf("tbl%0d rdata", i), io_rdata, tbl[i].exp_rd);
            check($sformatf("tbl%0d leds", i), {28'h0, LEDS}, {28'h0, tbl[i].exp_led});
        end

        // debounce: short glitch rejected, long hold accepted
        PUSH_KEY = 1'b1; idle(5);
        PUSH_KEY = 1'b0; idle(DB + 5);
        cyc(1'b1, 1'b0, BASE + 32'h04, 4'h0, 32'h0);
        check("glitch status", io_rdata, 32'h0);
        check("glitch event_pend", {31'h0, event_pend}, 32'h0);
        PUSH_KEY = 1'b1; idle(DB + 3);
        check("press event_pend", {31'h0, event_pend}, 32'h1);
        cyc(1'b1, 1'b0, BASE + 32'h04, 4'h0, 32'h0);
        check("press status", io_rdata, 32'h3);
        check("press cleared pend", {31'h0, event_pend}, 32'h0);
        cyc(1'b1, 1'b0, BASE + 32'h04, 4'h0, 32'h0);
        check("press status2", io_rdata, 32'h1);
        PUSH_KEY = 1'b0; idle(DB + 5);

        // timer with compare match
        cyc(1'b0, 1'b1, BASE + 32'h0C, 4'hF, 32'd3);
        cyc(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'h1);
        idle(30);
        cyc(1'b1, 1'b0, BASE + 32'h08, 4'h0, 32'h0);
        check("count after 30", io_rdata, 32'd3);
        check("match event_pend", {31'h0, event_pend}, 32'h1);
        cyc(1'b1, 1'b0, BASE + 32'h04, 4'h0, 32'h0);
        check("match status", io_rdata, 32'h4);
        cyc(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'h3);
        cyc(1'b1, 1'b0, BASE + 32'h08, 4'h0, 32'h0);
        check("count after clear", io_rdata, 32'd0);
        idle(8);
        cyc(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'h3);   // lands on a tick edge
        cyc(1'b1, 1'b0, BASE + 32'h08, 4'h0, 32'h0);
        check("clear beats tick", io_rdata, 32'd0);
        idle(9);
        cyc(1'b1, 1'b0, BASE + 32'h08, 4'h0, 32'h0);
        check("first tick after clear", io_rdata, 32'd1);
        cyc(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'h0);
        cyc(1'b0, 1'b1, BASE + 32'h0C, 4'hF, 32'd1);
        idle(12);
        check("static equality no match", {31'h0, event_pend}, 32'h0);
        cyc(1'b1, 1'b0, BASE + 32'h08, 4'h0, 32'h0);
        check("count frozen", io_rdata, 32'd1);

        // press completes on the same edge as a STATUS read
        PUSH_KEY = 1'b1; idle(DB + 1);
        cyc(1'b1, 1'b0, BASE + 32'h04, 4'h0, 32'h0);
        check("coincident status", io_rdata, 32'h0);
        check("coincident sticky", {31'h0, event_pend}, 32'h1);

        // asynchronous reset mid-count
        cyc(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'h1);
        cyc(1'b0, 1'b1, BASE + 32'h00, 4'hF, 32'hF);
        cyc(1'b1, 1'b0, BASE + 32'h00, 4'h0, 32'h0);
        check("pre-reset rdata", io_rdata, 32'hF);
        idle(5);
        #2 reset = 1'b0;
        #1;
        check("async reset rdata", io_rdata, 32'h0);
        check("async reset leds", {28'h0, LEDS}, 32'h0);
        check("async reset pend", {31'h0, event_pend}, 32'h0);
        PUSH_KEY = 1'b0;
        @(negedge clk); reset = 1'b1;
        cyc(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        check("post-reset ctrl", io_rdata, 32'h0);
        cyc(1'b1, 1'b0, BASE + 32'h08, 4'h0, 32'h0);
        check("post-reset count", io_rdata, 32'h0);

        // randomized traffic against the reference model
        apply_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        re, we, key;
            logic [31:0] a, wd;
            logic [3:0]  be;
            int          o;
            re = ($urandom_range(0, 9) < 3);
            we = ($urandom_range(0, 9) < 2);
            o  = $urandom_range(0, 7);
            a  = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a + 32'h40;
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wd = $urandom;
            if (o == 3) wd = 32'($urandom_range(0, 40));
            if (o == 4) wd = {30'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
            key = PUSH_KEY;
            if ($urandom_range(0, 39) == 0) key = ~key;
            PUSH_KEY = key;
            model_step(re, we, a, be, wd, key);
            cyc(re, we, a, be, wd);
            check($sformatf("rand%0d rdata", n), io_rdata, m_rdata);
            check($sformatf("rand%0d leds", n), {28'h0, LEDS}, {28'h0, m_led});
            check($sformatf("rand%0d pend", n), {31'h0, event_pend}, {31'h0, m_sp | m_sm});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
